// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: SRAM-like req/addr_ok/data_ok client to single-beat AXI; macro SRAM_AXI_BRIDGE_BRESP_WAIT_EN holds data_ok until the B handshake
module sram_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] axi_rdata,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, B, DONE} state_t;
`ifdef SRAM_AXI_BRIDGE_BRESP_WAIT_EN
  localparam state_t AFTER_W = B;
`else
  localparam state_t AFTER_W = DONE;
`endif
  state_t      r_state, w_next;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done, r_w_done;
  logic        w_aw_fire, w_w_fire, w_wr_done;
  assign w_aw_fire = awvalid & awready;
  assign w_w_fire  = wvalid & wready;
  assign w_wr_done = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);
  assign addr_ok   = r_state == IDLE;
  assign data_ok   = r_state == DONE;
  assign arvalid   = r_state == AR;
  assign rready    = r_state == R;
  assign awvalid   = (r_state == AW) & ~r_aw_done;
  assign wvalid    = (r_state == AW) & ~r_w_done;
`ifdef SRAM_AXI_BRIDGE_BRESP_WAIT_EN
  assign bready    = r_state == B;
`else
  assign bready    = 1'b1;
`endif
  assign araddr    = r_addr;
  assign awaddr    = r_addr;
  assign arsize    = {1'b0, r_size};
  assign awsize    = {1'b0, r_size};
  assign axi_wdata = r_wdata;
  assign axi_wstrb = r_wstrb;
  assign rdata     = r_rdata;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  // next-state: one outstanding transaction, AW and W tracked independently
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = wr ? AW : AR;
      AR:      if (arready) w_next = R;
      R:       if (rvalid) w_next = DONE;
      AW:      if (w_wr_done) w_next = AFTER_W;
      B:       if (bvalid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // request latch, write handshake flags and read data capture
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_size    <= '0;
      r_addr    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (addr_ok & req) begin
        r_size    <= size;
        r_addr    <= addr;
        r_wstrb   <= wstrb;
        r_wdata   <= wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire)  r_w_done  <= 1'b1;
      if (rready & rvalid) r_rdata <= axi_rdata;
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: vector table, random transactions with a latency/data model, and reset/back-to-back sequences
module tb_sram_axi_bridge;
`ifdef SRAM_AXI_BRIDGE_BRESP_WAIT_EN
  localparam bit BW = 1'b1;
`else
  localparam bit BW = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic req = 1'b0, wr = 1'b0;
  logic [1:0] size = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] wstrb = '0;
  logic addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] rdata, araddr, awaddr, axi_wdata;
  logic [2:0] arsize, awsize;
  logic [3:0] axi_wstrb;
  logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] axi_rdata = '0;
  int ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
  int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  logic [31:0] rval_q = '0, last_rd = '0;
  int n_cmp = 0, n_fail = 0;

  typedef struct {
    bit wr; logic [31:0] addr; logic [1:0] size; logic [3:0] wstrb;
    logic [31:0] wdata, rval; int da, dr, daw, dw, db, lat_on, lat_off;
  } vec_t;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .axi_rdata(axi_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // slave: each channel answers after a programmed number of wait cycles
  always @(negedge clk) begin
    arready = arvalid && ar_c == ar_d; ar_c = arvalid ? ar_c + 1 : 0;
    rvalid  = rready && r_c == r_d;    r_c  = rready ? r_c + 1 : 0;
    axi_rdata = rvalid ? rval_q : 32'h0;
    awready = awvalid && aw_c == aw_d; aw_c = awvalid ? aw_c + 1 : 0;
    wready  = wvalid && w_c == w_d;    w_c  = wvalid ? w_c + 1 : 0;
    bvalid  = bready && b_c == b_d;    b_c  = bready ? b_c + 1 : 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input vec_t v);
    int m;
    m = v.daw > v.dw ? v.daw : v.dw;
    if (!v.wr) return 3 + v.da + v.dr;
    return BW ? 3 + m + v.db : 2 + m;
  endfunction

  task automatic run(input vec_t v, input int lat);
    int cyc, got, cav, crv, cawv, cwv, cbv, bad;
    @(negedge clk); #1;
    ar_d = v.da; r_d = v.dr; aw_d = v.daw; w_d = v.dw; b_d = v.db; rval_q = v.rval;
    chk("addr_ok_idle", {31'b0, addr_ok}, 32'd1);
    req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wstrb = v.wstrb; wdata = v.wdata;
    @(negedge clk); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom); size = 2'($urandom);
    cyc = 1; got = -1; cav = 0; crv = 0; cawv = 0; cwv = 0; cbv = 0; bad = 0;
    while (got < 0 && cyc < 64) begin
      cav += int'(arvalid); crv += int'(rready); cawv += int'(awvalid); cwv += int'(wvalid);
      if (BW) cbv += int'(bready);
      if (arvalid && (araddr !== v.addr || arsize !== {1'b0, v.size})) bad++;
      if (awvalid && (awaddr !== v.addr || awsize !== {1'b0, v.size})) bad++;
      if (wvalid && (axi_wdata !== v.wdata || axi_wstrb !== v.wstrb)) bad++;
      if (addr_ok) bad++;
      if (data_ok) got = cyc;
      else begin @(negedge clk); #1; cyc++; end
    end
    chk("latency", got, lat);
    if (!v.wr) last_rd = v.rval;
    chk("rdata", rdata, last_rd);
    chk("fields_stable", bad, 0);
    chk("ar_cycles", cav, v.wr ? 0 : v.da + 1);
    chk("r_cycles", crv, v.wr ? 0 : v.dr + 1);
    chk("aw_cycles", cawv, v.wr ? v.daw + 1 : 0);
    chk("w_cycles", cwv, v.wr ? v.dw + 1 : 0);
    if (BW) chk("b_cycles", cbv, v.wr ? v.db + 1 : 0);
    @(negedge clk); #1;
    chk("data_ok_single", {31'b0, data_ok}, 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [7:0] acc_m, ok_m;
    int pulses, bad;
    tbl[0] = '{0, 32'h1C00_0004, 2, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3, 3};
    tbl[1] = '{1, 32'h0000_1000, 2, 4'b0011, 32'h1234_5678, 32'h0, 0, 0, 0, 3, 0, 6, 5};
    tbl[2] = '{1, 32'h0000_2000, 2, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0, 2, 0, 1, 6, 4};
    tbl[3] = '{0, 32'h0000_0003, 0, 4'h0, 32'h0, 32'h0000_00A5, 2, 1, 0, 0, 0, 6, 6};
    tbl[4] = '{1, 32'h0000_0102, 1, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 0, 1, 1, 2, 6, 3};
    tbl[5] = '{0, 32'h8000_0010, 1, 4'h0, 32'h0, 32'h5555_AAAA, 1, 3, 0, 0, 0, 7, 7};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_valids", {27'b0, arvalid, rready, awvalid, wvalid, bready & BW}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_latched", araddr | axi_wdata | {28'b0, axi_wstrb} | {29'b0, arsize}, 32'd0);
    resetn = 1'b1;
    #1 chk("rst_addr_ok", {31'b0, addr_ok}, 32'd1);
    foreach (tbl[i]) run(tbl[i], BW ? tbl[i].lat_on : tbl[i].lat_off);
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1)); v.addr = $urandom; v.size = 2'($urandom_range(0, 2));
      v.wstrb = 4'($urandom); v.wdata = $urandom; v.rval = $urandom;
      v.da = $urandom_range(0, 3); v.dr = $urandom_range(0, 3); v.daw = $urandom_range(0, 3);
      v.dw = $urandom_range(0, 3); v.db = $urandom_range(0, 3);
      run(v, model_lat(v));
    end
    // back-to-back reads with req held high across the first transaction
    @(negedge clk); #1;
    ar_d = 0; r_d = 0; rval_q = 32'h1111_2222;
    acc_m = '0; ok_m = '0; pulses = 0; bad = 0;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0040;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) addr = 32'h0000_0080;
      if (c == 4) rval_q = 32'h3333_4444;
      if (c == 5) req = 1'b0;
      acc_m[c] = addr_ok & req;
      ok_m[c] = data_ok;
      if (data_ok) begin
        pulses++;
        chk("b2b_rdata", rdata, pulses == 1 ? 32'h1111_2222 : 32'h3333_4444);
      end
      if (arvalid && c > 4 && araddr !== 32'h0000_0080) bad++;
      @(negedge clk); #1;
    end
    last_rd = 32'h3333_4444;
    chk("b2b_accept_cycles", {24'b0, acc_m}, 32'h11);
    chk("b2b_data_ok_cycles", {24'b0, ok_m}, 32'h88);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_araddr", bad, 0);
    // reset while in R with rvalid pending
    ar_d = 0; r_d = 5; rval_q = 32'h7777_8888;
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0100; size = 2'd2;
    @(negedge clk); #1; req = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mid_rst_in_r", {31'b0, rready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_rready", {31'b0, rready}, 32'd0);
    chk("mid_rst_idle", {30'b0, addr_ok, data_ok}, 32'd2);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    last_rd = 32'h0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      pulses += int'(data_ok);
    end
    chk("mid_rst_no_data_ok", pulses, 0);
    chk("mid_rst_rdata", rdata, 32'h0);
    v = '{0, 32'h0000_0200, 2, 4'h0, 32'h0, 32'h9999_0000, 0, 0, 0, 0, 0, 3, 3};
    run(v, 3);
    v = '{1, 32'h0000_0300, 2, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 0, 0, 0, 0, 3, 2};
    run(v, BW ? 3 : 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
